// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types, bundle widths and field offsets
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    // Inter-stage bundle widths
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 110;
    localparam int EX_MEM_W = 104;
    localparam int MEM_WB_W = 71;

    // MEM/WB field layout, shared by the stage packer and unpacker
    localparam int MEM_WB_RESULT_LSB = 0;
    localparam int MEM_WB_RESULT_W   = 32;
    localparam int MEM_WB_PC_LSB     = 32;
    localparam int MEM_WB_PC_W       = 32;
    localparam int MEM_WB_RD_LSB     = 64;
    localparam int MEM_WB_RD_W       = 5;
    localparam int MEM_WB_WE_BIT     = 69;
    localparam int MEM_WB_LIVE_BIT   = 70;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Count events, sticking at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with skid buffer and flush
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH          = 71,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1,
    parameter int               CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept, consume;

    // Handshake outputs decode only from registered state
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_SKID);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Next-state and storage updates; flush overrides the normal transitions
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (accept && consume) begin
                    main_d = in_data;
                end else if (accept) begin
                    state_d = ST_SKID;
                    skid_d  = in_data;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // The skid entry is the younger one, so it only ever moves into main
                if (consume) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = CLEAR_ON_FLUSH ? RESET_VAL : main_q;
            skid_d  = skid_q;
        end
    end

    // State and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and reference-model bench for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int W  = 71;
    localparam int WB = 16;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_data;
    logic [15:0]   stall_cnt;
    logic          in_ready_b, out_valid_b;
    logic [WB-1:0] out_data_b;
    logic [3:0]    stall_cnt_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .WIDTH(W), .RESET_VAL('0), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(
        .WIDTH(WB), .RESET_VAL(16'hBEEF), .CLEAR_ON_FLUSH(1'b0), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data[WB-1:0]),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .stall_cnt(stall_cnt_b)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] q[$];
    bit           acc, con, e_valid, e_ready;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

        // Reset for two cycles, with an input offered that must be ignored
        tick();
        in_valid = 1'b1; in_data = 71'h77;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_data_b", out_data_b, 16'hBEEF);
        check("rst_stall", stall_cnt, 0);

        // Basic pass, one-cycle latency
        rst = 1'b0; in_valid = 1'b1; in_data = 71'h155;
        tick();
        check("pass_valid", out_valid, 1);
        check("pass_data", out_data, 71'h155);
        in_valid = 1'b0;
        tick();
        check("pass_drain", out_valid, 0);

        // Streaming 1..8 without bubbles
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = W'(i);
            tick();
            check($sformatf("stream_v%0d", i), out_valid, 1);
            check($sformatf("stream_d%0d", i), out_data, i);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drain", out_valid, 0);
        check("stream_stall", stall_cnt, 0);

        // Backpressure: A in main, B into skid, C held upstream
        in_valid = 1'b1; in_data = 71'hA;
        tick();
        out_ready = 1'b0; in_data = 71'hB;
        tick();
        check("bp_skid_in_ready", in_ready, 0);
        check("bp_skid_data", out_data, 71'hA);
        check("bp_stall1", stall_cnt, 1);
        in_data = 71'hC;
        repeat (3) tick();
        check("bp_hold_data", out_data, 71'hA);
        check("bp_hold_valid", out_valid, 1);
        check("bp_stall4", stall_cnt, 4);
        out_ready = 1'b1;
        tick();
        check("bp_rel_b", out_data, 71'hB);
        check("bp_rel_in_ready", in_ready, 1);
        tick();
        check("bp_rel_c", out_data, 71'hC);
        in_valid = 1'b0;
        tick();
        check("bp_drain", out_valid, 0);
        check("bp_stall_keep", stall_cnt, 4);
        check("bp_stall_keep_b", stall_cnt_b, 4);

        // Flush while in SKID, with D offered in the same cycle
        out_ready = 1'b0; in_valid = 1'b1; in_data = 71'hA;
        tick();
        in_data = 71'hB;
        tick();
        check("fl_pre_in_ready", in_ready, 0);
        flush = 1'b1; in_data = 71'hD;
        tick();
        check("fl_valid", out_valid, 0);
        check("fl_data_clear", out_data, 0);
        check("fl_data_held_b", out_data_b, 16'h000A);
        check("fl_stall_kept", stall_cnt, 6);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("fl_d_dropped", out_valid, 0);

        // Saturation on the 4-bit counter
        in_valid = 1'b1; in_data = 71'hE;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("sat_b", stall_cnt_b, 15);
        check("sat_wide", stall_cnt, 26);
        check("sat_data_b", out_data_b, 16'h000E);

        // Reset in the middle of a SKID hold
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 71'h1A;
        tick();
        out_ready = 1'b0; in_data = 71'h1B;
        tick();
        repeat (4) tick();
        check("mid_pre_stall", stall_cnt, 5);
        check("mid_pre_in_ready", in_ready, 0);
        rst = 1'b1; in_data = 71'hF;
        tick();
        check("mid_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_stall", stall_cnt, 0);
        check("mid_data", out_data, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check("mid_no_accept", out_valid, 0);

        // Random valid/ready traffic against a two-deep FIFO reference
        q.delete();
        for (int c = 0; c < 300; c++) begin
            e_valid  = (q.size() > 0);
            e_ready  = (q.size() < 2);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {39'(c), $urandom()};
            acc = in_valid && e_ready;
            con = e_valid && out_ready;
            tick();
            if (con) void'(q.pop_front());
            if (acc) q.push_back(in_data);
            check($sformatf("rnd_valid_%0d", c), out_valid, (q.size() > 0));
            check($sformatf("rnd_ready_%0d", c), in_ready, (q.size() < 2));
            if (q.size() > 0)
                check($sformatf("rnd_data_%0d", c), out_data, q[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
